// File: rtl/arena_scanner.sv
// Serialises the Life arena one row at a time into a valid/ready cell stream,
// row 0 / column 0 first, and counts live cells for the generation's population.
module arena_scanner #(
  parameter int ARENA_WIDTH  = 10,
  parameter int ARENA_HEIGHT = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic                   ready,
  output logic [9:0]             arena_row_select,
  input  logic [ARENA_WIDTH-1:0] arena_columns,
  output logic                   cell_valid,
  input  logic                   cell_ready,
  output logic                   cell_data,
  output logic                   cell_last_in_row,
  output logic                   cell_last_in_frame,
  output logic [19:0]            population
);

  localparam int COL_W = (ARENA_WIDTH > 1) ? $clog2(ARENA_WIDTH) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(ARENA_WIDTH - 1);
  localparam logic [9:0]       ROW_LAST = 10'(ARENA_HEIGHT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;

  logic [1:0]             state_reg, state_next;
  logic [9:0]             row_reg, row_next;
  logic [COL_W-1:0]       col_reg, col_next;
  logic [ARENA_WIDTH-1:0] shift_reg, shift_next;
  logic [19:0]            pop_reg, pop_next;

  logic in_shift;
  logic col_last;
  logic row_last;
  logic accept;

  assign in_shift = (state_reg == S_SHIFT);
  assign col_last = (col_reg == COL_LAST);
  assign row_last = (row_reg == ROW_LAST);
  assign accept   = in_shift & cell_ready;

  // All outputs decode from registered state, so cell_valid never sees cell_ready.
  assign ready              = (state_reg == S_IDLE);
  assign cell_valid         = in_shift;
  assign cell_data          = in_shift & shift_reg[0];
  assign cell_last_in_row   = in_shift & col_last;
  assign cell_last_in_frame = in_shift & col_last & row_last;
  assign arena_row_select   = (state_reg == S_IDLE) ? 10'd0 : row_reg;
  assign population         = pop_reg;

  always_comb begin
    state_next = state_reg;
    row_next   = row_reg;
    col_next   = col_reg;
    shift_next = shift_reg;
    pop_next   = pop_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = S_FETCH;
          row_next   = 10'd0;
          pop_next   = 20'd0;
        end
      end
      S_FETCH: begin
        // Row is snapshotted here; later arena writes cannot disturb its stream.
        shift_next = arena_columns;
        col_next   = '0;
        state_next = S_SHIFT;
      end
      S_SHIFT: begin
        if (accept) begin
          shift_next = shift_reg >> 1;
          pop_next   = pop_reg + {19'd0, shift_reg[0]};
          if (col_last) begin
            if (row_last) begin
              state_next = S_IDLE;
            end else begin
              row_next   = row_reg + 10'd1;
              state_next = S_FETCH;
            end
          end else begin
            col_next = col_reg + 1'b1;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      row_reg   <= '0;
      col_reg   <= '0;
      shift_reg <= '0;
      pop_reg   <= '0;
    end else begin
      state_reg <= state_next;
      row_reg   <= row_next;
      col_reg   <= col_next;
      shift_reg <= shift_next;
      pop_reg   <= pop_next;
    end
  end

endmodule

// File: tb/tb_arena_scanner.sv
// Drives three scanner configurations (10x10, 4x3, 1x1) and compares each cell
// stream and population against a row/column walk of the bench's own arena copy.
module tb_arena_scanner;

  localparam int W_CFG [3] = '{10, 4, 1};
  localparam int H_CFG [3] = '{10, 3, 1};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]       start_s = '0;
  logic [2:0]       cell_ready_s = '0;
  logic [2:0]       ready_w, valid_w, data_w, lir_w, lif_w;
  logic [2:0][9:0]  sel_w;
  logic [2:0][19:0] pop_w;
  logic [9:0]       arena_mem [3][10];
  logic [9:0]       cols0;
  logic [3:0]       cols1;
  logic [0:0]       cols2;

  int n_checks = 0;
  int n_fail = 0;

  assign cols0 = arena_mem[0][sel_w[0][3:0]];
  assign cols1 = arena_mem[1][sel_w[1][3:0]][3:0];
  assign cols2 = arena_mem[2][sel_w[2][3:0]][0:0];

  arena_scanner #(.ARENA_WIDTH(10), .ARENA_HEIGHT(10)) u_big (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .ready(ready_w[0]),
    .arena_row_select(sel_w[0]), .arena_columns(cols0), .cell_valid(valid_w[0]),
    .cell_ready(cell_ready_s[0]), .cell_data(data_w[0]), .cell_last_in_row(lir_w[0]),
    .cell_last_in_frame(lif_w[0]), .population(pop_w[0]));

  arena_scanner #(.ARENA_WIDTH(4), .ARENA_HEIGHT(3)) u_small (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .ready(ready_w[1]),
    .arena_row_select(sel_w[1]), .arena_columns(cols1), .cell_valid(valid_w[1]),
    .cell_ready(cell_ready_s[1]), .cell_data(data_w[1]), .cell_last_in_row(lir_w[1]),
    .cell_last_in_frame(lif_w[1]), .population(pop_w[1]));

  arena_scanner #(.ARENA_WIDTH(1), .ARENA_HEIGHT(1)) u_one (
    .clk(clk), .rst_n(rst_n), .start(start_s[2]), .ready(ready_w[2]),
    .arena_row_select(sel_w[2]), .arena_columns(cols2), .cell_valid(valid_w[2]),
    .cell_ready(cell_ready_s[2]), .cell_data(data_w[2]), .cell_last_in_row(lir_w[2]),
    .cell_last_in_frame(lif_w[2]), .population(pop_w[2]));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic randomize_arena(input int k);
    for (int r = 0; r < 10; r++) arena_mem[k][r] = 10'($urandom);
  endtask

  // Caller is positioned at a negedge with the instance idle.
  task automatic run_scan(input int k, input bit rand_ready, input bit spam, input bit scramble);
    bit exp_d[$];
    bit exp_lr[$];
    bit exp_lf[$];
    int total, exp_pop, run_pop, cells, n, limit;
    bit done, acc, prev_valid, prev_acc, prev_d, prev_lr, prev_lf, e_d;
    total = W_CFG[k] * H_CFG[k];
    exp_pop = 0;
    for (int r = 0; r < H_CFG[k]; r++) begin
      for (int c = 0; c < W_CFG[k]; c++) begin
        exp_d.push_back(arena_mem[k][r][c]);
        exp_lr.push_back(c == W_CFG[k] - 1);
        exp_lf.push_back((c == W_CFG[k] - 1) && (r == H_CFG[k] - 1));
        exp_pop += int'(arena_mem[k][r][c]);
      end
    end
    limit = H_CFG[k] * (W_CFG[k] + 1) * 6 + 20;
    check_eq("ready_before_start", ready_w[k], 1);
    start_s[k] = 1'b1;
    n = 0; done = 0; run_pop = 0; cells = 0;
    prev_valid = 0; prev_acc = 0; prev_d = 0; prev_lr = 0; prev_lf = 0;
    while (!done) begin
      @(negedge clk);
      n++;
      start_s[k] = 1'b0;
      if (n == 1) begin
        check_eq("fetch_ready_low", ready_w[k], 0);
        check_eq("fetch_no_valid", valid_w[k], 0);
        check_eq("fetch_row0_select", sel_w[k], 0);
      end
      if (n == 2) check_eq("first_valid", valid_w[k], 1);
      if (prev_valid && !prev_acc) begin
        check_eq("stall_valid", valid_w[k], 1);
        check_eq("stall_data", data_w[k], prev_d);
        check_eq("stall_last_row", lir_w[k], prev_lr);
        check_eq("stall_last_frame", lif_w[k], prev_lf);
      end
      check_eq("running_population", pop_w[k], run_pop);
      if (ready_w[k] && n > 1) begin
        done = 1;
      end else if (n > limit) begin
        check_eq("timeout_ready", ready_w[k], 1);
        done = 1;
      end else begin
        if (spam) start_s[k] = 1'($urandom_range(0, 1));
        cell_ready_s[k] = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
        acc = valid_w[k] && cell_ready_s[k];
        if (acc) begin
          cells++;
          if (exp_d.size() == 0) begin
            check_eq("extra_cell", cells, total);
          end else begin
            e_d = exp_d.pop_front();
            check_eq("cell_data", data_w[k], e_d);
            check_eq("cell_last_in_row", lir_w[k], exp_lr.pop_front());
            check_eq("cell_last_in_frame", lif_w[k], exp_lf.pop_front());
            run_pop += int'(e_d);
          end
        end
        // Overwrite the row already fetched: the stream must not change.
        if (scramble && valid_w[k]) arena_mem[k][sel_w[k][3:0]] = 10'($urandom);
        prev_valid = valid_w[k]; prev_acc = acc;
        prev_d = data_w[k]; prev_lr = lir_w[k]; prev_lf = lif_w[k];
      end
    end
    start_s[k] = 1'b0;
    cell_ready_s[k] = 1'b0;
    if (!rand_ready) check_eq("ready_return_cycle", n, H_CFG[k] * (W_CFG[k] + 1) + 1);
    check_eq("cell_count", cells, total);
    check_eq("final_population", pop_w[k], exp_pop);
    $display("scan inst=%0d %0dx%0d cells=%0d population=%0d cycles=%0d",
             k, W_CFG[k], H_CFG[k], cells, pop_w[k], n);
  endtask

  initial begin
    int n;
    for (int k = 0; k < 3; k++)
      for (int r = 0; r < 10; r++) arena_mem[k][r] = '0;

    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check_eq("rst_ready", ready_w[k], 1);
      check_eq("rst_valid", valid_w[k], 0);
      check_eq("rst_data", data_w[k], 0);
      check_eq("rst_last_row", lir_w[k], 0);
      check_eq("rst_last_frame", lif_w[k], 0);
      check_eq("rst_select", sel_w[k], 0);
      check_eq("rst_population", pop_w[k], 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Empty 10x10 arena, sink always ready.
    run_scan(0, 0, 0, 0);

    arena_mem[1][0] = 10'b0001;
    arena_mem[1][1] = 10'b1010;
    arena_mem[1][2] = 10'b1111;
    run_scan(1, 0, 0, 0);
    run_scan(1, 1, 0, 0);
    // Start spam during the scan, then an immediate relaunch.
    run_scan(1, 1, 1, 0);
    run_scan(1, 1, 0, 1);

    // Abort with reset while streaming row 1.
    randomize_arena(0);
    arena_mem[0][0] = 10'h3ff;
    start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    cell_ready_s[0] = 1'b1;
    n = 0;
    while (!(valid_w[0] && sel_w[0] == 10'd1) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_eq("reach_row1", sel_w[0], 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("abort_valid", valid_w[0], 0);
    check_eq("abort_ready", ready_w[0], 1);
    check_eq("abort_population", pop_w[0], 0);
    check_eq("abort_select", sel_w[0], 0);
    repeat (2) @(negedge clk);
    check_eq("abort_held_valid", valid_w[0], 0);
    rst_n = 1'b1;
    cell_ready_s[0] = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("post_abort_valid", valid_w[0], 0);
    run_scan(0, 1, 0, 0);

    // Single-cell arena.
    arena_mem[2][0] = 10'h3ff;
    run_scan(2, 0, 0, 0);

    for (int it = 0; it < 3; it++) begin
      for (int k = 0; k < 3; k++) begin
        randomize_arena(k);
        run_scan(k, it != 0, it == 2, it == 1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/arena_scanner.md
# arena_scanner

Frame reader for the Life arena: on a start pulse it walks every arena row through the arena row-select/read port and emits the cells as a serial stream under a valid/ready handshake, row 0 first and column 0 first. It also counts live cells to give a population figure for the generation. It sits between the arena storage and the display/serial-output path. It is the read-side counterpart of the generation engines that drive `arena_row_select` / `arena_columns_new` / `arena_columns_write`.

## Interface
- `ARENA_WIDTH`, default 10: cells per row; constraint `ARENA_WIDTH` ≥ 1.
- `ARENA_HEIGHT`, default 10: rows; constraint 1 ≤ `ARENA_HEIGHT` ≤ 1024.
- Combined constraint: `ARENA_WIDTH*ARENA_HEIGHT` < 2^20.

Ports:
- `clk`  in  1  sole clock; everything is rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a scan; accepted only when `ready`=1.
- `ready`  out  1  1 = idle and `population` valid.
- `arena_row_select`  out  10  row address to the arena read port.
- `arena_columns`  in  `ARENA_WIDTH`  row data; combinational read, valid in the same cycle as `arena_row_select`; bit i = column i.
- `cell_valid`  out  1  cell stream valid.
- `cell_ready`  in  1  sink accepts the cell.
- `cell_data`  out  1  cell state, 1 = alive.
- `cell_last_in_row`  out  1  current cell is column `ARENA_WIDTH`-1.
- `cell_last_in_frame`  out  1  current cell is the last column of the last row.
- `population`  out  20  live-cell count of the last completed or in-progress scan.

## Operation
- FSM states: IDLE, FETCH, SHIFT.
- IDLE:
  - `ready`=1; `cell_valid`=0; `arena_row_select`=0.
  - `start`=1 → FETCH with row=0; `population` cleared to 0 at the same edge.
- FETCH (1 cycle):
  - `arena_row_select`=row.
  - `arena_columns` captured into a `ARENA_WIDTH`-bit shift register; column counter set to 0.
  - → SHIFT.
- SHIFT:
  - `cell_valid`=1; `cell_data`=shift register bit 0.
  - `arena_row_select` holds the current row (don't-care to storage).
  - On `cell_valid` & `cell_ready`: shift right by 1, column counter +1, `population` += `cell_data`.
  - Accepted cell with column = `ARENA_WIDTH`-1 and row < `ARENA_HEIGHT`-1 → row+1, go to FETCH.
  - Accepted cell with column = `ARENA_WIDTH`-1 and row = `ARENA_HEIGHT`-1 → IDLE.
- `cell_last_in_row` = SHIFT & column = `ARENA_WIDTH`-1.
- `cell_last_in_frame` = `cell_last_in_row` & row = `ARENA_HEIGHT`-1.
- Arithmetic:
  - row and column counters are sized to hold their maxima and never wrap within a scan.
  - `population` is unsigned and cannot overflow under the size constraint.
- `start` while `ready`=0 is ignored; no queuing.
- `ARENA_WIDTH`=1: each row is one FETCH plus one transfer. `ARENA_HEIGHT`=1: the first last-in-row cell is also last-in-frame.
- Arena contents changing after a row's FETCH do not affect that row's stream.

## Timing
- Reset values (async, on `rst_n`=0):
  - state IDLE; `ready`=1.
  - `cell_valid`, `cell_data`, `cell_last_in_row`, `cell_last_in_frame` = 0.
  - `arena_row_select`=0; `population`=0; counters and shift register = 0.
- Reset asserted mid-scan aborts immediately. No further cells are emitted. The scan is not resumed after release.
- Handshake:
  - Once `cell_valid`=1, `cell_valid`, `cell_data` and both last flags are held stable until accepted.
  - `cell_valid` never depends combinationally on `cell_ready`.
- Latency, with `start` accepted at edge T:
  - `ready`=0 from T+1; the FETCH of row 0 is in cycle T+1.
  - First `cell_valid` is in cycle T+2.
- Throughput with `cell_ready` held at 1: per row, 1 FETCH cycle plus `ARENA_WIDTH` transfer cycles. The final transfer is in cycle T+`ARENA_HEIGHT`*(`ARENA_WIDTH`+1). `ready` returns to 1 in the following cycle.
- `population` is final and stable whenever `ready`=1.

## Test plan
- Reset, then `ARENA_WIDTH`=`ARENA_HEIGHT`=10 with an empty arena, `cell_ready`=1, one start pulse → 100 cells, all `cell_data`=0. `cell_last_in_row` fires 10 times; `cell_last_in_frame` fires once, on the 100th cell. `ready` returns to 1 exactly 110 cycles after the start edge; `population`=0.
- `ARENA_WIDTH`=4, `ARENA_HEIGHT`=3, rows 0..2 = 4'b0001, 4'b1010, 4'b1111 → stream 1000 0101 1111 (column 0 first); `population`=7.
- Same 4×3 arena, `cell_ready` toggled in a pseudo-random pattern → identical 12-cell sequence. Data and flags are stable through every stall; `population`=7.
- `start` pulsed repeatedly during a scan → no effect on the stream or `population`. A start one cycle after `ready` rises launches a new scan, and `population` clears to 0.
- `rst_n` driven low while streaming row 1 → `cell_valid`=0, `ready`=1, `population`=0 immediately. After release, a fresh start streams from row 0, column 0.
- Full 10×10 arena of 1s with `ARENA_WIDTH`=1, `ARENA_HEIGHT`=1 configuration run separately → a single cell with both last flags high; `population`=1; `ready` returns 2 cycles after the start edge.
